// File: rtl/attn_pkg.sv
// Shared precision definitions for the attention precision selector and
// the downstream attention_av_multiply stage.
package attn_pkg;

    typedef enum logic [1:0] {
        PREC_INT4 = 2'b00,
        PREC_INT8 = 2'b01,
        PREC_FP16 = 2'b10
    } prec_t;

    // Operand widths of each precision class.
    localparam int WIDTH_INT4  = 4;
    localparam int WIDTH_INT8  = 8;
    localparam int WIDTH_FP16  = 16;

    // Multiply-stage cycles spent per element for each precision class.
    localparam int CYCLES_INT4 = 1;
    localparam int CYCLES_INT8 = 2;
    localparam int CYCLES_FP16 = 4;

    // Map a column attention mass to a precision code. The FP16 test wins,
    // so an INT8 threshold above the FP16 threshold is harmless. A column
    // that qualifies for FP16 but finds the budget exhausted drops to INT8.
    function automatic prec_t classify(input logic [31:0] sum,
                                       input logic [31:0] thr_int8,
                                       input logic [31:0] thr_fp16,
                                       input logic        budget_ok);
        prec_t code;
        if ((sum >= thr_fp16) && budget_ok) begin
            code = PREC_FP16;
        end else if ((sum >= thr_fp16) || (sum >= thr_int8)) begin
            code = PREC_INT8;
        end else begin
            code = PREC_INT4;
        end
        return code;
    endfunction

endpackage

// File: rtl/attention_precision_selector.sv
// Walks the attention matrix column by column, sums each column, and
// assigns each column a precision code from two thresholds under an FP16
// budget. All outputs are registered.
module attention_precision_selector
    import attn_pkg::*;
#(
    parameter int A_ROWS   = 8,
    parameter int NUM_COLS = 8,
    parameter int WIDTH    = 16,
    parameter int SUM_W    = WIDTH + $clog2(A_ROWS),
    localparam int CNT_W   = $clog2(NUM_COLS + 1),
    localparam int ROW_W   = (A_ROWS > 1) ? $clog2(A_ROWS) : 1,
    localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic [A_ROWS-1:0][NUM_COLS-1:0][WIDTH-1:0]  a_mem,
    input  logic [SUM_W-1:0]                            thr_int8,
    input  logic [SUM_W-1:0]                            thr_fp16,
    input  logic [CNT_W-1:0]                            fp16_budget,
    output logic [NUM_COLS-1:0][1:0]                    precision_sel,
    output logic [CNT_W-1:0]                            num_fp16,
    output logic [CNT_W-1:0]                            num_int8,
    output logic [CNT_W-1:0]                            num_int4,
    output logic                                        busy,
    output logic                                        done
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ACCUM    = 2'b01,
        ST_CLASSIFY = 2'b10,
        ST_DONE     = 2'b11
    } state_t;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(A_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

    state_t             state_r;
    logic [ROW_W-1:0]   row_r;
    logic [COL_W-1:0]   col_r;
    logic [SUM_W-1:0]   sum_r;
    logic [SUM_W-1:0]   thr_int8_r;
    logic [SUM_W-1:0]   thr_fp16_r;
    logic [CNT_W-1:0]   budget_r;

    logic [WIDTH-1:0]   elem_s;
    logic [SUM_W-1:0]   sum_next_s;
    logic               budget_ok_s;
    prec_t              code_s;

    // Element fetch, running-sum adder and classification of the current column.
    always_comb begin
        elem_s      = a_mem[row_r][col_r];
        sum_next_s  = sum_r + SUM_W'(elem_s);
        budget_ok_s = (num_fp16 < budget_r);
        code_s      = classify(32'(sum_r), 32'(thr_int8_r), 32'(thr_fp16_r), budget_ok_s);
    end

    // Control FSM with registered datapath state and outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            row_r         <= '0;
            col_r         <= '0;
            sum_r         <= '0;
            thr_int8_r    <= '0;
            thr_fp16_r    <= '0;
            budget_r      <= '0;
            precision_sel <= {NUM_COLS{2'b10}};
            num_fp16      <= '0;
            num_int8      <= '0;
            num_int4      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        thr_int8_r <= thr_int8;
                        thr_fp16_r <= thr_fp16;
                        budget_r   <= fp16_budget;
                        num_fp16   <= '0;
                        num_int8   <= '0;
                        num_int4   <= '0;
                        row_r      <= '0;
                        col_r      <= '0;
                        sum_r      <= '0;
                        busy       <= 1'b1;
                        state_r    <= ST_ACCUM;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    sum_r <= sum_next_s;
                    if (row_r == ROW_LAST) begin
                        row_r   <= '0;
                        state_r <= ST_CLASSIFY;
                    end else begin
                        row_r <= row_r + ROW_W'(1);
                    end
                end
                ST_CLASSIFY: begin
                    precision_sel[col_r] <= code_s;
                    case (code_s)
                        PREC_FP16: num_fp16 <= num_fp16 + CNT_W'(1);
                        PREC_INT8: num_int8 <= num_int8 + CNT_W'(1);
                        default:   num_int4 <= num_int4 + CNT_W'(1);
                    endcase
                    row_r <= '0;
                    sum_r <= '0;
                    if (col_r == COL_LAST) begin
                        state_r <= ST_DONE;
                    end else begin
                        col_r   <= col_r + COL_W'(1);
                        state_r <= ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_attention_precision_selector.sv
// Self-checking bench for attention_precision_selector: directed boundary
// cases plus randomized matrices compared against a column-sum model.
module tb_attention_precision_selector;

    localparam int R  = 8;
    localparam int C  = 8;
    localparam int W  = 16;
    localparam int SW = 19;
    localparam int CW = 4;
    localparam int LATENCY = 1 + C * (R + 1);

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic                          start;
    logic [R-1:0][C-1:0][W-1:0]    a_mem;
    logic [SW-1:0]                 thr_int8;
    logic [SW-1:0]                 thr_fp16;
    logic [CW-1:0]                 fp16_budget;
    logic [C-1:0][1:0]             precision_sel;
    logic [CW-1:0]                 num_fp16;
    logic [CW-1:0]                 num_int8;
    logic [CW-1:0]                 num_int4;
    logic                          busy;
    logic                          done;

    int tests = 0;
    int fails = 0;

    int exp_sel [C];
    int exp_n16, exp_n8, exp_n4;

    attention_precision_selector dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .a_mem         (a_mem),
        .thr_int8      (thr_int8),
        .thr_fp16      (thr_fp16),
        .fp16_budget   (fp16_budget),
        .precision_sel (precision_sel),
        .num_fp16      (num_fp16),
        .num_int8      (num_int8),
        .num_int4      (num_int4),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: sum each column as an integer, then hand out FP16 slots
    // to qualifying columns in ascending column order until the budget ends.
    task automatic model(input int t8, input int t16, input int bud);
        int s;
        exp_n16 = 0; exp_n8 = 0; exp_n4 = 0;
        for (int c = 0; c < C; c++) begin
            s = 0;
            for (int r = 0; r < R; r++) s += int'(a_mem[r][c]);
            if (s >= t16 && exp_n16 < bud) begin
                exp_sel[c] = 2; exp_n16++;
            end else if (s >= t16 || s >= t8) begin
                exp_sel[c] = 1; exp_n8++;
            end else begin
                exp_sel[c] = 0; exp_n4++;
            end
        end
    endtask

    task automatic fill_col(input int c, input logic [W-1:0] v);
        for (int r = 0; r < R; r++) a_mem[r][c] = v;
    endtask

    // mode 0: plain pass; 1: disturb threshold/budget inputs one cycle after
    // start; 2: extra start pulse with different settings mid-pass.
    task automatic run_pass(input string tag, input int t8, input int t16,
                            input int bud, input int mode);
        int n;
        model(t8, t16, bud);
        @(negedge clk);
        thr_int8    = SW'(t8);
        thr_fp16    = SW'(t16);
        fp16_budget = CW'(bud);
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ".busy_start"}, 32'(busy), 32'd1);
        check({tag, ".done_start"}, 32'(done), 32'd0);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (mode == 1 && n == 1) begin
                thr_fp16    = SW'(0);
                fp16_budget = CW'(0);
                thr_int8    = SW'(19'h7FFFF);
            end
            if (mode == 2 && n == 20) begin
                thr_fp16    = SW'(0);
                fp16_budget = CW'(8);
                start       = 1'b1;
            end
            if (mode == 2 && n == 21) start = 1'b0;
            if (!done && n < LATENCY) begin
                if (busy !== 1'b1) check({tag, ".busy_mid"}, 32'(busy), 32'd1);
            end
        end
        check({tag, ".latency"}, 32'(n), 32'(LATENCY));
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        for (int c = 0; c < C; c++)
            check($sformatf("%s.sel%0d", tag, c), 32'(precision_sel[c]), 32'(exp_sel[c]));
        check({tag, ".num_fp16"}, 32'(num_fp16), 32'(exp_n16));
        check({tag, ".num_int8"}, 32'(num_int8), 32'(exp_n8));
        check({tag, ".num_int4"}, 32'(num_int4), 32'(exp_n4));
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        a_mem       = '0;
        thr_int8    = '0;
        thr_fp16    = '0;
        fp16_budget = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.sel",   32'(precision_sel), 32'h0000_AAAA);
        check("rst.n16",   32'(num_fp16), 32'd0);
        check("rst.n8",    32'(num_int8), 32'd0);
        check("rst.n4",    32'(num_int4), 32'd0);
        check("rst.busy",  32'(busy), 32'd0);
        check("rst.done",  32'(done), 32'd0);
        rst_n = 1'b1;

        // Threshold boundaries.
        for (int c = 0; c < C; c++) fill_col(c, W'($urandom_range(0, 16'hFFFF)));
        fill_col(0, 16'h1000);
        fill_col(1, 16'h0400);
        fill_col(2, 16'h03FF);
        fill_col(3, 16'h0C00);
        run_pass("bound", 32'h02000, 32'h06000, 8, 0);
        check("bound.c0_fixed", 32'(precision_sel[0]), 32'd2);
        check("bound.c1_fixed", 32'(precision_sel[1]), 32'd1);
        check("bound.c2_fixed", 32'(precision_sel[2]), 32'd0);
        check("bound.c3_fixed", 32'(precision_sel[3]), 32'd2);

        // Budget cap.
        for (int c = 0; c < C; c++) fill_col(c, 16'h1000);
        run_pass("budget", 32'h02000, 32'h06000, 3, 0);
        check("budget.sel_fixed", 32'(precision_sel), 32'h0000_556A);
        check("budget.n16_fixed", 32'(num_fp16), 32'd3);

        // Zero budget.
        run_pass("bud0", 32'h02000, 32'h06000, 0, 0);

        // Width: full-scale elements must not wrap.
        for (int c = 0; c < C; c++) fill_col(c, 16'hFFFF);
        run_pass("wide", 32'h7FFF8, 32'h7FFF8, 8, 0);
        check("wide.sel_fixed", 32'(precision_sel), 32'h0000_AAAA);

        // Shadow latching and ignored mid-pass start.
        for (int c = 0; c < C; c++) fill_col(c, W'(16'h0800 * (c + 1)));
        run_pass("shadow", 32'h08000, 32'h20000, 2, 1);
        run_pass("restart", 32'h08000, 32'h20000, 2, 2);

        // Reset during column 4 accumulation.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4 * (R + 1) + 3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst.sel",  32'(precision_sel), 32'h0000_AAAA);
        check("midrst.n16",  32'(num_fp16), 32'd0);
        check("midrst.n8",   32'(num_int8), 32'd0);
        check("midrst.n4",   32'(num_int4), 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        run_pass("after_rst", 32'h04000, 32'h10000, 4, 0);

        // Randomized passes.
        for (int i = 0; i < 6; i++) begin
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    a_mem[r][c] = W'($urandom_range(0, 16'hFFFF) >> $urandom_range(0, 6));
            run_pass($sformatf("rand%0d", i), int'($urandom_range(0, 19'h40000)),
                     int'($urandom_range(0, 19'h60000)), int'($urandom_range(0, 9)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
